pid_mul_sequencer: RTL and testbench

- Time-multiplexes the single 16-bit combinational multiplier of the PID datapath to compute u = Kp*e + Ki*I + Kd*D.
- Integral and derivative state are held internally.
- Accepts one error sample per start handshake and returns the control output a fixed 3 cycles later.
- Sits between the error-sample source and the actuator output register.

---
 rtl/pid_pkg.sv | 15 +
 rtl/pid_mul_sequencer_mul16.sv | 16 +
 rtl/pid_mul_sequencer.sv | 141 ++++++++++++++
 tb/tb_pid_mul_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types for the PID multiply sequencer: datapath width, word type and FSM states.
package pid_pkg;

  localparam int unsigned W = 16;

  typedef logic [W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_P = 2'd1,
    MUL_I = 2'd2,
    MUL_D = 2'd3
  } state_t;

endpackage

// File: rtl/pid_mul_sequencer_mul16.sv
// Shared 16x16 combinational multiplier; returns the low word of the product,
// which is the same for signed and unsigned operands.
module pid_mul16
  import pid_pkg::*;
(
  input  word_t a,
  input  word_t b,
  output word_t p
);

  logic [2*W-1:0] full;

  assign full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign p    = full[W-1:0];

endmodule

// File: rtl/pid_mul_sequencer.sv
// PID output u = Kp*e + Ki*I + Kd*D computed over three cycles on one shared multiplier.
module pid_mul_sequencer
  import pid_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clr,
  input  logic [W-1:0] err_in,
  input  logic [W-1:0] kp,
  input  logic [W-1:0] ki,
  input  logic [W-1:0] kd,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] u_out,
  output logic [W-1:0] integ_out
);

  state_t state_q, state_d;
  word_t  e_q, e_d;
  word_t  e_prev_q, e_prev_d;
  word_t  integ_q, integ_d;
  word_t  kp_q, kp_d;
  word_t  ki_q, ki_d;
  word_t  kd_q, kd_d;
  word_t  sum_q, sum_d;
  word_t  u_q, u_d;
  logic   done_q, done_d;

  word_t  op_a, op_b, prod;

  pid_mul16 u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // Operands depend on state only, so the multiplier is quiet while idle.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      MUL_P: begin
        op_a = kp_q;
        op_b = e_q;
      end
      MUL_I: begin
        op_a = ki_q;
        op_b = integ_q;
      end
      MUL_D: begin
        op_a = kd_q;
        op_b = e_q - e_prev_q;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    e_prev_d = e_prev_q;
    integ_d  = integ_q;
    kp_d     = kp_q;
    ki_d     = ki_q;
    kd_d     = kd_q;
    sum_d    = sum_q;
    u_d      = u_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          e_d     = err_in;
          kp_d    = kp;
          ki_d    = ki;
          kd_d    = kd;
          // A clear arriving with the sample restarts history from this sample.
          integ_d = (clr ? '0 : integ_q) + err_in;
          if (clr) e_prev_d = '0;
          state_d = MUL_P;
        end else if (clr) begin
          integ_d  = '0;
          e_prev_d = '0;
        end
      end
      MUL_P: begin
        sum_d   = prod;
        state_d = MUL_I;
      end
      MUL_I: begin
        sum_d   = sum_q + prod;
        state_d = MUL_D;
      end
      MUL_D: begin
        u_d      = sum_q + prod;
        done_d   = 1'b1;
        e_prev_d = e_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      e_q      <= '0;
      e_prev_q <= '0;
      integ_q  <= '0;
      kp_q     <= '0;
      ki_q     <= '0;
      kd_q     <= '0;
      sum_q    <= '0;
      u_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      e_prev_q <= e_prev_d;
      integ_q  <= integ_d;
      kp_q     <= kp_d;
      ki_q     <= ki_d;
      kd_q     <= kd_d;
      sum_q    <= sum_d;
      u_q      <= u_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign u_out     = u_q;
  assign integ_out = integ_q;

endmodule

// File: tb/tb_pid_mul_sequencer.sv
// Directed bench for pid_mul_sequencer with hand-computed expected outputs.
module tb_pid_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic [15:0] err_in;
  logic [15:0] kp;
  logic [15:0] ki;
  logic [15:0] kd;
  logic        busy;
  logic        done;
  logic [15:0] u_out;
  logic [15:0] integ_out;

  int checks = 0;
  int errors = 0;

  pid_mul_sequencer #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .err_in    (err_in),
    .kp        (kp),
    .ki        (ki),
    .kd        (kd),
    .busy      (busy),
    .done      (done),
    .u_out     (u_out),
    .integ_out (integ_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse and returns at the falling edge of the done cycle.
  task automatic run_op(input logic [15:0] e, input logic [15:0] p,
                        input logic [15:0] i, input logic [15:0] d);
    err_in = e;
    kp     = p;
    ki     = i;
    kd     = d;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    clr    = 1'b0;
    err_in = '0;
    kp     = '0;
    ki     = '0;
    kd     = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_u", u_out, 0);
    chk("rst_integ", integ_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic timing, with gain/err changes during busy that must not matter
    @(negedge clk);
    kp = 16'd2; ki = 16'd0; kd = 16'd0; err_in = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; kp = 16'd7; err_in = 16'd9;
    chk("basic_busy1", busy, 1);
    chk("basic_done1", done, 0);
    @(negedge clk);
    chk("basic_busy2", busy, 1);
    @(negedge clk);
    chk("basic_busy3", busy, 1);
    chk("basic_done3", done, 0);
    @(negedge clk);
    chk("basic_done", done, 1);
    chk("basic_idle", busy, 0);
    chk("basic_u", u_out, 10);
    chk("basic_integ", integ_out, 5);
    @(negedge clk);
    chk("basic_done_drop", done, 0);
    chk("basic_u_hold", u_out, 10);

    // State carry-over, second start in the done cycle
    do_reset();
    run_op(16'd3, 16'd1, 16'd1, 16'd1);
    chk("carry1_done", done, 1);
    chk("carry1_u", u_out, 9);
    chk("carry1_integ", integ_out, 3);
    run_op(16'd5, 16'd1, 16'd1, 16'd1);
    chk("carry2_done", done, 1);
    chk("carry2_u", u_out, 15);
    chk("carry2_integ", integ_out, 8);

    // Clear in idle, then restart
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_integ", integ_out, 0);
    chk("clr_busy", busy, 0);
    run_op(16'd3, 16'd1, 16'd1, 16'd1);
    chk("clr_u", u_out, 9);
    chk("clr_u_integ", integ_out, 3);

    // Clear together with start: integ=6, D=6 -> 6 + 2*6 + 6
    @(negedge clk);
    clr = 1'b1;
    run_op(16'd6, 16'd1, 16'd2, 16'd1);
    chk("clrstart_done", done, 1);
    chk("clrstart_u", u_out, 24);
    chk("clrstart_integ", integ_out, 6);

    // Negative error then wrap-around
    do_reset();
    run_op(16'hFFFF, 16'd3, 16'd0, 16'd0);
    chk("neg_u", u_out, 16'hFFFD);
    run_op(16'h0100, 16'h0100, 16'd0, 16'd0);
    chk("wrap_done", done, 1);
    chk("wrap_u", u_out, 16'h0000);

    // Start held high while busy
    do_reset();
    err_in = 16'd7; kp = 16'd1; ki = 16'd0; kd = 16'd0; start = 1'b1;
    @(negedge clk);
    chk("hold_busy1", busy, 1);
    chk("hold_nodone1", done, 0);
    @(negedge clk);
    chk("hold_integ2", integ_out, 7);
    chk("hold_nodone2", done, 0);
    @(negedge clk);
    chk("hold_nodone3", done, 0);
    @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_u", u_out, 7);
    chk("hold_integ", integ_out, 7);
    @(negedge clk);
    start = 1'b0;
    chk("hold_restart_busy", busy, 1);
    chk("hold_restart_done", done, 0);
    chk("hold_restart_integ", integ_out, 14);
    @(negedge clk);
    @(negedge clk);
    chk("hold2_nodone", done, 0);
    @(negedge clk);
    chk("hold2_done", done, 1);
    chk("hold2_u", u_out, 7);

    // Reset mid-operation
    @(negedge clk);
    kp = 16'd2; ki = 16'd0; kd = 16'd0; err_in = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_u", u_out, 0);
    chk("abort_integ", integ_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end
    chk("abort_u_final", u_out, 0);
    chk("abort_integ_final", integ_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
